// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder that adds two WIDTH-bit operands LSB-first,
// one bit per clock, through two half-adder stages and a registered carry.
// Operands arrive over a valid/ready handshake. The WIDTH-bit sum and the
// carry-out leave over a second valid/ready handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sreg;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             h_s;
    logic             h_c;
    logic             sum_bit;
    logic             carry_next;

    // One bit-slice of addition, built from two half-adder stages
    always_comb begin
        h_s        = sa[0] ^ sb[0];
        h_c        = sa[0] & sb[0];
        sum_bit    = h_s ^ carry;
        carry_next = h_c | (h_s & carry);
    end

    // Handshake flags come straight from the state register
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Sequencer: accept operands, shift one bit per clock, then hold the result until it is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sreg  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg  <= {sum_bit, sreg[WIDTH-1:1]};
                    sa    <= {1'b0, sa[WIDTH-1:1]};
                    sb    <= {1'b0, sb[WIDTH-1:1]};
                    carry <= carry_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= {sum_bit, sreg[WIDTH-1:1]};
                        cout  <= carry_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder built around the team's half-adder cell. The block accepts two WIDTH-bit operands over a valid/ready handshake. It adds them LSB-first, one bit per clock, using two half-adder stages plus a registered carry. It then presents the WIDTH-bit sum and carry-out over a second valid/ready handshake. It is the sequential stage that feeds operand bits into the half-adder datapath and consumes its s/c outputs, so wide additions need only one bit-slice of logic.

## Interface
- WIDTH, default 8: operand and sum width in bits. Legal range is WIDTH >= 2.
- Clock and reset (already decided): one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b are valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  operand A; sampled only on the accept edge
- b  input  WIDTH  operand B; sampled only on the accept edge
- out_valid  output  1  sum/cout hold a new result
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  registered sum (a+b) mod 2^WIDTH
- cout  output  1  registered carry-out of the MSB

## Operation
- State machine: IDLE, SHIFT, DONE. The state register, a/b shift registers, sum shift register, carry flop, bit counter (clog2(WIDTH+1) bits) and output registers all reset to zero / IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept when in_valid && in_ready at an edge: load a→sa, b→sb, clear carry, clear counter, go to SHIFT.
- SHIFT, each edge:
  - First half-adder stage: h_s = sa[0]^sb[0], h_c = sa[0]&sb[0].
  - Second half-adder stage: bit = h_s^carry, carry_next = h_c | (h_s&carry).
  - Shift the sum register right with `bit` entering the MSB. Shift sa and sb right with zero fill. Increment the counter.
  - On the edge where the counter reaches WIDTH-1→WIDTH: load the sum output register from the completed sum register (including this cycle's bit), load cout from carry_next, go to DONE.
- DONE:
  - out_valid=1. sum and cout are stable.
  - On out_valid && out_ready at an edge: go to IDLE.
- Output hold:
  - sum and cout keep their value after returning to IDLE, until the next result overwrites them.
  - In SHIFT, sum and cout do not change; only the internal shift register moves.
- Arithmetic: {cout,sum} = a + b exactly (WIDTH+1-bit result), with no overflow saturation. Wrap-around is reported only through cout.
- Ignored inputs:
  - in_valid while not in IDLE is ignored; operands are not queued.
  - Changes on a/b after the accept edge have no effect.
  - out_ready outside DONE is ignored.

## Timing
- in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid or out_ready.
- Latency: accept at edge E0. The SHIFT edges are E1..E_WIDTH. out_valid goes high after E_WIDTH, i.e. WIDTH cycles after the accept edge.
- Result handshake at edge Ek: state is IDLE after Ek, so in_ready=1 in the following cycle. A new accept is therefore possible at Ek+1.
- Best-case throughput: one addition per WIDTH+2 cycles.
- Backpressure: DONE holds indefinitely while out_ready=0, with sum, cout and out_valid unchanged.
- Reset:
  - Asserting rst_n low at any time, including mid-SHIFT, immediately forces IDLE and clears all registers. out_valid=0, sum=0, cout=0, in_ready=1.
  - A partial operation is discarded and never reported.
  - Deasserting rst_n is effective at the next rising edge.

## Test plan
- Reset values: assert rst_n low mid-cycle with no clock activity → in_ready=1, out_valid=0, sum=8'h00, cout=0, checked asynchronously.
- Carry chain (WIDTH=8): a=8'hFF, b=8'h01 accepted at E0 → out_valid rises after E8 with sum=8'h00, cout=1. in_ready=0 during E1..E8.
- No-carry pattern: a=8'hA5, b=8'h5A → sum=8'hFF, cout=0. Then a=8'h80, b=8'h80 → sum=8'h00, cout=1. Zero operands → sum=8'h00, cout=0.
- Backpressure and ignored input: a=8'h3C, b=8'h0F with out_ready=0 for 5 cycles → sum=8'h4B, cout=0 held stable, out_valid held. in_valid=1 with a=8'h11 during SHIFT/DONE is not accepted; the next result comes only after a fresh accept.
- Reset mid-operation: a=8'hFF, b=8'hFF, rst_n low after E3 → outputs return to reset values and no out_valid pulse appears. Next op a=8'hFF, b=8'hFF → sum=8'hFE, cout=1.
- Randomized back-to-back with out_ready=1 (1000 ops, WIDTH=8 and WIDTH=4) → every result matches a+b and the accept-to-out_valid spacing is exactly WIDTH cycles.
